// File: rtl/m68k_bus_master_if.sv
// 68000-style local bus: address, data, strobes and responder handshake.
// The master drives the address, data and strobe lines; the responder returns data, DTACK and BERR.
interface m68k_bus_master_if;
  logic [22:0] bus_addr;
  logic [15:0] bus_dout;
  logic        bus_doe;
  logic [15:0] bus_din;
  logic        as_n;
  logic        uds_n;
  logic        lds_n;
  logic        rw;
  logic        dtack_n;
  logic        berr_n;

  modport master (
    output bus_addr, bus_dout, bus_doe, as_n, uds_n, lds_n, rw,
    input  bus_din, dtack_n, berr_n
  );

  modport slave (
    input  bus_addr, bus_dout, bus_doe, as_n, uds_n, lds_n, rw,
    output bus_din, dtack_n, berr_n
  );
endinterface

// File: rtl/m68k_bus_master.sv
// Bus-cycle initiator for the 68000-style local bus: it runs read and write cycles, waits for
// DTACK or BERR, and turns a missing DTACK into a bus error after TIMEOUT clocks.
module m68k_bus_master #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk16,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [22:0] addr,
  input  logic [1:0]  be,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [15:0] rdata,
  m68k_bus_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, ADDR, STRB, WAIT, DONE, RECOVER} state_t;

  typedef struct packed {
    logic        as_n;
    logic        uds_n;
    logic        lds_n;
    logic        rw;
    logic        doe;
    logic [22:0] addr;
    logic [15:0] dout;
  } bus_reg_t;

  localparam bus_reg_t BUS_RST = '{as_n: 1'b1, uds_n: 1'b1, lds_n: 1'b1, rw: 1'b1,
                                   doe: 1'b0, addr: '0, dout: '0};
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  state_t          state_q, state_d;
  bus_reg_t        bus_q, bus_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            we_q, we_d, errf_q, errf_d;
  logic [1:0]      be_q, be_d;
  logic            busy_d, ack_d, err_d;
  logic [15:0]     rdata_d;

  always_ff @(posedge clk16) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bus_q   <= BUS_RST;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= 2'b00;
      errf_q  <= 1'b0;
      busy    <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      errf_q  <= errf_d;
      busy    <= busy_d;
      ack     <= ack_d;
      err     <= err_d;
      rdata   <= rdata_d;
    end
  end

  // Each state's actions are the values that take effect on the edge that leaves it,
  // which gives E0 = address valid, E1 = AS low, E2 = write DS low.
  always_comb begin
    state_d = state_q;
    bus_d   = bus_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    errf_d  = errf_q;
    busy_d  = busy;
    ack_d   = 1'b0;
    err_d   = err;
    rdata_d = rdata;
    unique case (state_q)
      IDLE: if (req) begin
        if (be == 2'b00) begin
          ack_d = 1'b1;
          err_d = 1'b1;
        end else begin
          state_d    = ADDR;
          busy_d     = 1'b1;
          we_d       = we;
          be_d       = be;
          bus_d.addr = addr;
          bus_d.rw   = ~we;
          if (we) begin
            bus_d.doe  = 1'b1;
            bus_d.dout = wdata;
          end
        end
      end
      ADDR: begin
        state_d    = STRB;
        bus_d.as_n = 1'b0;
        if (!we_q) begin
          bus_d.uds_n = ~be_q[1];
          bus_d.lds_n = ~be_q[0];
        end
      end
      STRB: begin
        state_d = WAIT;
        cnt_d   = '0;
        // Write DS trails AS by one clock, so the data has settled before the strobes assert.
        if (we_q) begin
          bus_d.uds_n = ~be_q[1];
          bus_d.lds_n = ~be_q[0];
        end
      end
      WAIT: begin
        if (!bus.berr_n) begin
          state_d = DONE;
          errf_d  = 1'b1;
        end else if (!bus.dtack_n) begin
          state_d = DONE;
          errf_d  = 1'b0;
        end else if (cnt_q == TO_MAX) begin
          state_d = DONE;
          errf_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      DONE: begin
        if (!we_q && !errf_q) rdata_d = bus.bus_din;
        bus_d.as_n  = 1'b1;
        bus_d.uds_n = 1'b1;
        bus_d.lds_n = 1'b1;
        bus_d.doe   = 1'b0;
        bus_d.rw    = 1'b1;
        ack_d       = 1'b1;
        err_d       = errf_q;
        cnt_d       = '0;
        state_d     = RECOVER;
      end
      RECOVER: begin
        // Wait for the responder to release before starting another cycle. A stuck
        // responder is abandoned after TIMEOUT clocks.
        if ((bus.dtack_n && bus.berr_n) || cnt_q == TO_MAX) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.bus_addr = bus_q.addr;
  assign bus.bus_dout = bus_q.dout;
  assign bus.bus_doe  = bus_q.doe;
  assign bus.as_n     = bus_q.as_n;
  assign bus.uds_n    = bus_q.uds_n;
  assign bus.lds_n    = bus_q.lds_n;
  assign bus.rw       = bus_q.rw;
endmodule

// File: tb/tb_m68k_bus_master.sv
// Bench for m68k_bus_master: directed and random cycles checked against a timing and data
// model built from bus-cycle rules, with DTACK and BERR played by an in-bench responder.
module tb_m68k_bus_master;
  localparam int TIMEOUT = 255;

  logic        clk16 = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [22:0] addr = '0;
  logic [1:0]  be = '0;
  logic [15:0] wdata = '0;
  logic        busy, ack, err;
  logic [15:0] rdata;

  m68k_bus_master_if bif ();

  m68k_bus_master #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk16(clk16), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .busy(busy), .ack(ack), .err(err), .rdata(rdata), .bus(bif)
  );

  always #5 clk16 = ~clk16;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_rdata = '0;

  task automatic tick;
    @(posedge clk16);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle from request to return to IDLE. dly < 0 means the responder never answers.
  // The responder holds DTACK (and BERR when use_berr) for hold edges after the ack edge.
  task automatic run_cycle(input logic w, input logic [22:0] a, input logic [1:0] b,
                           input logic [15:0] wd, input logic [15:0] din, input int dly,
                           input bit use_berr, input int hold, input bit pulse);
    int  exp_ack, exp_free, ack_at, acks;
    bit  e_err, dt;
    e_err    = use_berr || dly < 0;
    exp_ack  = (dly < 0) ? 4 + TIMEOUT : 4 + dly;
    exp_free = exp_ack + 1 + ((dly < 0) ? 0 : hold);
    req = 1'b1; we = w; addr = a; be = b; wdata = wd; bif.bus_din = din;
    tick;
    req = 1'b0; we = 1'($urandom); addr = 23'($urandom); wdata = 16'($urandom); be = 2'($urandom);
    chk("e0_addr", 32'(bif.bus_addr), 32'(a));
    chk("e0_rw", 32'(bif.rw), 32'(!w));
    chk("e0_doe", 32'(bif.bus_doe), 32'(w));
    if (w) chk("e0_dout", 32'(bif.bus_dout), 32'(wd));
    chk("e0_as_n", 32'(bif.as_n), 32'd1);
    chk("e0_busy", 32'(busy), 32'd1);
    ack_at = -1;
    acks   = 0;
    for (int k = 1; k <= exp_free + 3; k++) begin
      dt = (dly >= 0) && (k >= 3 + dly) && (ack_at < 0 || k <= ack_at + hold);
      bif.dtack_n = !dt;
      bif.berr_n  = !(dt && use_berr);
      req = pulse && (k == 2);
      tick;
      if (k == 1) begin
        chk("e1_as_n", 32'(bif.as_n), 32'd0);
        chk("e1_uds_n", 32'(bif.uds_n), w ? 32'd1 : 32'(!b[1]));
        chk("e1_lds_n", 32'(bif.lds_n), w ? 32'd1 : 32'(!b[0]));
      end
      if (k == 2) begin
        chk("e2_uds_n", 32'(bif.uds_n), 32'(!b[1]));
        chk("e2_lds_n", 32'(bif.lds_n), 32'(!b[0]));
        if (w) chk("e2_dout", 32'(bif.bus_dout), 32'(wd));
      end
      if (ack) begin
        acks++;
        if (ack_at < 0) ack_at = k;
      end
      if (ack_at == k) begin
        chk("ack_err", 32'(err), 32'(e_err));
        chk("rel_as_n", 32'(bif.as_n), 32'd1);
        chk("rel_ds_n", 32'({bif.uds_n, bif.lds_n}), 32'd3);
        chk("rel_doe", 32'(bif.bus_doe), 32'd0);
        chk("rel_rw", 32'(bif.rw), 32'd1);
      end
      if (k == exp_free - 1) chk("busy_hold", 32'(busy), 32'd1);
      if (k == exp_free)     chk("busy_drop", 32'(busy), 32'd0);
    end
    bif.dtack_n = 1'b1;
    bif.berr_n  = 1'b1;
    req = 1'b0;
    chk("ack_edge", 32'(ack_at), 32'(exp_ack));
    chk("ack_count", 32'(acks), 32'd1);
    if (!w && !e_err) m_rdata = din;
    chk("rdata", 32'(rdata), 32'(m_rdata));
  endtask

  initial begin
    int acks;
    bif.dtack_n = 1'b1;
    bif.berr_n  = 1'b1;
    bif.bus_din = '0;
    tick;
    tick;
    chk("rst_strobes", 32'({bif.as_n, bif.uds_n, bif.lds_n, bif.rw}), 32'hf);
    chk("rst_doe", 32'(bif.bus_doe), 32'd0);
    chk("rst_addr", 32'(bif.bus_addr), 32'd0);
    chk("rst_dout", 32'(bif.bus_dout), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_ack_err_busy", 32'({ack, err, busy}), 32'd0);
    reset_n = 1'b1;
    tick;

    // Read of byte address 0x080000 (word address 0x040000).
    run_cycle(1'b0, 23'h040000, 2'b11, 16'h0000, 16'hBEEF, 0, 1'b0, 0, 1'b0);
    // Write of the lower byte, DTACK four clocks late.
    run_cycle(1'b1, 23'h012345, 2'b01, 16'h1234, 16'h5555, 4, 1'b0, 0, 1'b0);
    // No DTACK: timeout error.
    run_cycle(1'b0, 23'h7fffff, 2'b10, 16'h0000, 16'hAAAA, -1, 1'b0, 0, 1'b0);
    // BERR and DTACK together, held three extra clocks.
    run_cycle(1'b0, 23'h000100, 2'b11, 16'h0000, 16'hCAFE, 1, 1'b1, 3, 1'b0);
    // A req pulse during the cycle is ignored.
    run_cycle(1'b0, 23'h000200, 2'b01, 16'h0000, 16'h600D, 2, 1'b0, 0, 1'b1);

    // be == 00: immediate error ack, no bus activity.
    req = 1'b1; we = 1'b0; be = 2'b00; addr = 23'h000300;
    tick;
    req = 1'b0;
    chk("be0_ack", 32'(ack), 32'd1);
    chk("be0_err", 32'(err), 32'd1);
    chk("be0_busy", 32'(busy), 32'd0);
    chk("be0_as_n", 32'(bif.as_n), 32'd1);
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (ack) acks++;
      chk("be0_as_n_idle", 32'(bif.as_n), 32'd1);
    end
    chk("be0_single_ack", 32'(acks), 32'd0);

    // Reset while waiting for DTACK.
    req = 1'b1; we = 1'b1; be = 2'b11; addr = 23'h000400; wdata = 16'h9999;
    tick;
    req = 1'b0;
    for (int k = 0; k < 4; k++) tick;
    chk("pre_rst_as_n", 32'(bif.as_n), 32'd0);
    reset_n = 1'b0;
    tick;
    chk("mid_rst_strobes", 32'({bif.as_n, bif.uds_n, bif.lds_n, bif.rw}), 32'hf);
    chk("mid_rst_doe", 32'(bif.bus_doe), 32'd0);
    chk("mid_rst_ack_busy", 32'({ack, busy}), 32'd0);
    m_rdata = '0;
    reset_n = 1'b1;
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      tick;
      if (ack) acks++;
    end
    chk("post_rst_no_ack", 32'(acks), 32'd0);
    run_cycle(1'b0, 23'h000500, 2'b11, 16'h0000, 16'h1357, 0, 1'b0, 0, 1'b0);

    // Random cycles.
    for (int i = 0; i < 24; i++) begin
      run_cycle(1'($urandom), 23'($urandom), 2'($urandom_range(1, 3)), 16'($urandom),
                16'($urandom), int'($urandom_range(0, 6)), ($urandom_range(0, 4) == 0),
                int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
